// File: rtl/d_ff_pipe_en_pkg.sv
// Shared helpers for the enable-gated register pipeline: per-edge action
// decode and the occupancy counter width.
package d_ff_pipe_en_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SHIFT = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_RESET = 2'd3
    } pipe_act_t;

    // Counter must hold 0..depth; never narrower than one bit.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic pipe_act_t decode_act(input logic rst, input logic flush, input logic en);
        pipe_act_t act;
        act = ACT_HOLD;
        if (rst)
            act = ACT_RESET;
        else if (flush)
            act = ACT_FLUSH;
        else if (en)
            act = ACT_SHIFT;
        return act;
    endfunction

endpackage

// File: rtl/d_ff_pipe_en_stage.sv
// One pipeline stage: WIDTH-bit data plus a valid bit.
// Priority: reset > clear-valid (data holds) > enable > hold.
module d_ff_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_q,
    output logic             o_vld
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_data <= RST_VAL;
            r_vld  <= 1'b0;
        end else if (i_clr) begin
            r_vld  <= 1'b0;
        end else if (i_en) begin
            r_data <= i_d;
            r_vld  <= i_vld;
        end
    end

    assign o_q   = r_data;
    assign o_vld = r_vld;

endmodule

// File: rtl/d_ff_pipe_en.sv
// Enable-gated WIDTH x DEPTH delay line with per-stage valid, flush and a
// registered occupancy count maintained incrementally alongside the stages.
module d_ff_pipe_en
    import d_ff_pipe_en_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         out_valid,
    output logic [occ_width(DEPTH)-1:0]  occ
);

    localparam int               OCC_W   = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    // Element k is the input of stage k; element DEPTH is the last stage output.
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic             w_vld  [DEPTH+1];
    pipe_act_t        w_act;
    logic [OCC_W-1:0] r_occ;

    assign w_data[0] = d;
    assign w_vld[0]  = in_valid;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            d_ff_pipe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk   (clk),
                .i_rst (rst),
                .i_clr (flush),
                .i_en  (en),
                .i_d   (w_data[k]),
                .i_vld (w_vld[k]),
                .o_q   (w_data[k+1]),
                .o_vld (w_vld[k+1])
            );
        end
    endgenerate

    always_comb begin
        w_act = decode_act(rst, flush, en);
    end

    // Modular arithmetic at OCC_W is exact: the true result is always 0..DEPTH.
    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH: r_occ <= '0;
            ACT_SHIFT:            r_occ <= r_occ + OCC_W'(in_valid) - OCC_W'(w_vld[DEPTH]);
            default:              r_occ <= r_occ;
        endcase
    end

    assign q         = w_data[DEPTH];
    assign out_valid = w_vld[DEPTH];
    assign occ       = r_occ;

    a_occ_range: assert property (@(posedge clk) disable iff (rst) r_occ <= OCC_MAX);

endmodule

// File: tb/tb_d_ff_pipe_en.sv
// Bench for d_ff_pipe_en: DEPTH=4 and DEPTH=1 instances share stimulus and are
// compared every cycle against a history-of-accepted-items reference model.
module tb_d_ff_pipe_en;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, en, flush, in_valid;
    logic [7:0] d;
    logic [7:0] q4, q1;
    logic       ov4, ov1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       vld;
    } item_t;
    typedef item_t item_q_t[$];

    // Oldest entry is what sits on q; the window holds the last DEPTH accepted items.
    item_q_t h4, h1;

    always #5 clk = ~clk;

    d_ff_pipe_en #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q4), .out_valid(ov4), .occ(occ4)
    );

    d_ff_pipe_en #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q1), .out_valid(ov1), .occ(occ1)
    );

    function automatic item_q_t model_step(input item_q_t h, input int depth, input logic r,
                                           input logic f, input logic e, input logic iv,
                                           input logic [7:0] dd);
        item_q_t n;
        item_t   it;
        n = h;
        if (r) begin
            n = {};
            it.data = RV;
            it.vld  = 1'b0;
            for (int i = 0; i < depth; i++) n.push_back(it);
        end else if (f) begin
            foreach (n[i]) n[i].vld = 1'b0;
        end else if (e) begin
            it.data = dd;
            it.vld  = iv;
            n.push_back(it);
            while (n.size() > depth) void'(n.pop_front());
        end
        return n;
    endfunction

    function automatic int count_vld(input item_q_t h);
        int c = 0;
        foreach (h[i]) if (h[i].vld) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic e, input logic iv,
                       input logic [7:0] dd);
        rst = r; flush = f; en = e; in_valid = iv; d = dd;
        @(posedge clk);
        h4 = model_step(h4, 4, r, f, e, iv, dd);
        h1 = model_step(h1, 1, r, f, e, iv, dd);
        #1;
        check("q_d4",   32'(q4),   32'(h4[0].data));
        check("ov_d4",  32'(ov4),  32'(h4[0].vld));
        check("occ_d4", 32'(occ4), 32'(count_vld(h4)));
        check("q_d1",   32'(q1),   32'(h1[0].data));
        check("ov_d1",  32'(ov1),  32'(h1[0].vld));
        check("occ_d1", 32'(occ1), 32'(count_vld(h1)));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = '0;

        // reset, then idle with en=0: everything holds at reset values
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        check("rst_q",   32'(q4),   32'hA5);
        check("rst_occ", 32'(occ4), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'($urandom));
        check("hold_q", 32'(q4), 32'hA5);

        // streaming 1..5, then drain
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 1, 8'(i));
        check("stream_occ", 32'(occ4), 32'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'($urandom));

        // stall with a full pipe, then drain with in_valid=0
        for (int i = 10; i <= 13; i++) cyc(0, 0, 1, 1, 8'(i));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'($urandom));
        check("stall_q",   32'(q4),   32'd10);
        check("stall_occ", 32'(occ4), 32'd4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'($urandom));

        // bubbles
        cyc(0, 0, 1, 1, 8'd7);
        cyc(0, 0, 1, 0, 8'd8);
        cyc(0, 0, 1, 1, 8'd9);
        cyc(0, 0, 1, 0, 8'd6);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 8'($urandom));
            if (occ4 > 3'd2) check("bubble_occ_max", 32'(occ4), 32'd2);
        end

        // flush colliding with an enabled valid input
        for (int i = 20; i <= 22; i++) cyc(0, 0, 1, 1, 8'(i));
        cyc(0, 1, 1, 1, 8'h55);
        check("flush_occ", 32'(occ4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            check("flush_no55", 32'(ov4 && q4 == 8'h55), 32'd0);
        end

        // reset mid-stream with en=1, then DEPTH=1 rebuild
        for (int i = 30; i <= 33; i++) cyc(0, 0, 1, 1, 8'(i));
        cyc(1, 0, 1, 1, 8'h77);
        check("midrst_q",   32'(q4),   32'hA5);
        check("midrst_occ", 32'(occ4), 32'd0);
        cyc(0, 0, 1, 1, 8'd3);
        check("d1_q",   32'(q1),   32'd3);
        check("d1_occ", 32'(occ1), 32'd1);
        cyc(0, 0, 0, 0, 8'd9);
        cyc(0, 0, 0, 1, 8'd4);
        check("d1_hold_q", 32'(q1), 32'd3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
